// File: rtl/bp_me_pkg.sv
// Shared BedRock memory-endpoint definitions: message types, payload masks,
// responder FSM states and the stream beat-count helper.
package bp_me_pkg;

    // BedRock memory message types
    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'b0000,
        e_bedrock_mem_wr    = 4'b0001,
        e_bedrock_mem_uc_rd = 4'b0010,
        e_bedrock_mem_uc_wr = 4'b0011,
        e_bedrock_mem_pre   = 4'b0100,
        e_bedrock_mem_amo   = 4'b0101
    } bp_bedrock_mem_type_e;

    // Bit n set: a message of type n carries data beats
    localparam logic [15:0] mem_cmd_payload_mask_gp  = 16'b0000_0000_0010_1010; // wr, uc_wr, amo
    localparam logic [15:0] mem_resp_payload_mask_gp = 16'b0000_0000_0010_0101; // rd, uc_rd, amo

    // Width of beat counts; covers 2^7 bytes at the narrowest legal beat
    localparam int bp_me_beat_cnt_width_gp = 8;

    typedef enum logic [1:0] {
        e_ready,
        e_wr_stream,
        e_resp
    } bp_me_mem_responder_state_e;

    // beats = max(1, 2^size / beat_bytes)
    function automatic logic [bp_me_beat_cnt_width_gp-1:0] bp_me_stream_beats
        (input logic [2:0] size, input int unsigned data_width);
        int unsigned bytes;
        int unsigned beat_bytes;
        int unsigned beats;
        bytes      = 32'd1 << size;
        beat_bytes = data_width / 8;
        beats      = (bytes > beat_bytes) ? (bytes / beat_bytes) : 32'd1;
        return beats[bp_me_beat_cnt_width_gp-1:0];
    endfunction

endpackage

// File: rtl/bp_me_mem_beat_counter.sv
// Beat counter for a streamed message plus the critical-word-first index
// generator: beat k lands on the start index with its low lg(beats) bits
// replaced by (start + k) mod beats.
module bp_me_mem_beat_counter
    import bp_me_pkg::*;
#(
    parameter int idx_width_p = 8
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                load_i,
    input  logic [idx_width_p-1:0]              start_idx_i,
    input  logic [bp_me_beat_cnt_width_gp-1:0]  beats_i,
    input  logic                                incr_i,
    output logic [idx_width_p-1:0]              idx_o,
    output logic                                final_o
);

    localparam int cw_lp = bp_me_beat_cnt_width_gp;

    logic [cw_lp-1:0]       cnt_q, cnt_d;
    logic [cw_lp-1:0]       beats_q;
    logic [idx_width_p-1:0] base_q;
    logic [idx_width_p-1:0] wrap_mask;

    // Next count: beat 0 is consumed in the load cycle, so a load starts at 1
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = cw_lp'(1);
        end else if (incr_i) begin
            cnt_d = cnt_q + cw_lp'(1);
        end
    end

    // Counter and burst-window registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset_n_i) begin
            cnt_q   <= '0;
            beats_q <= '0;
            base_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load_i) begin
                beats_q <= beats_i;
                base_q  <= start_idx_i;
            end
        end
    end

    // Wrap index inside the block-aligned window and final-beat flag
    always_comb begin
        wrap_mask = idx_width_p'(beats_q - cw_lp'(1));
        idx_o     = (base_q & ~wrap_mask) | ((base_q + idx_width_p'(cnt_q)) & wrap_mask);
        final_o   = (cnt_q == (beats_q - cw_lp'(1)));
    end

endmodule

// File: rtl/bp_me_mem_responder.sv
// Memory-side BedRock endpoint: accepts streamed mem_cmd messages, executes
// them against a flop-array memory and returns streamed mem_resp messages.
module bp_me_mem_responder
    import bp_me_pkg::*;
#(
    parameter int paddr_width_p = 40,
    parameter int data_width_p  = 64,
    parameter int mem_words_p   = 256
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic [3:0]               mem_cmd_msg_type_i,
    input  logic [paddr_width_p-1:0] mem_cmd_addr_i,
    input  logic [2:0]               mem_cmd_size_i,
    input  logic [data_width_p-1:0]  mem_cmd_data_i,
    input  logic                     mem_cmd_v_i,
    input  logic                     mem_cmd_last_i,
    output logic                     mem_cmd_ready_and_o,

    output logic [3:0]               mem_resp_msg_type_o,
    output logic [paddr_width_p-1:0] mem_resp_addr_o,
    output logic [2:0]               mem_resp_size_o,
    output logic [data_width_p-1:0]  mem_resp_data_o,
    output logic                     mem_resp_v_o,
    output logic                     mem_resp_last_o,
    input  logic                     mem_resp_ready_and_i,

    output logic                     protocol_error_o
);

    localparam int beat_bytes_lp    = data_width_p / 8;
    localparam int lg_beat_bytes_lp = $clog2(beat_bytes_lp);
    localparam int idx_width_lp     = $clog2(mem_words_p);
    localparam int cw_lp            = bp_me_beat_cnt_width_gp;

    bp_me_mem_responder_state_e state_q;
    logic                       ready_q;
    logic                       resp_v_q;
    logic                       resp_last_q;
    logic [data_width_p-1:0]    resp_data_q;
    logic [3:0]                 resp_type_q;
    logic [paddr_width_p-1:0]   resp_addr_q;
    logic [2:0]                 resp_size_q;
    logic                       protocol_error_q;

    logic [data_width_p-1:0]    mem_q [mem_words_p];

    // Header decode of the incoming beat
    logic                       cmd_hs, resp_hs;
    logic                       cmd_has_data, resp_has_data, cmd_is_amo;
    logic                       cmd_streams, resp_streams;
    logic [cw_lp-1:0]           cmd_beats;
    logic [idx_width_lp-1:0]    hdr_idx;
    logic                       hdr_single_beat;

    assign cmd_hs        = mem_cmd_v_i & ready_q;
    assign resp_hs       = resp_v_q & mem_resp_ready_and_i;
    assign cmd_has_data  = mem_cmd_payload_mask_gp[mem_cmd_msg_type_i];
    assign resp_has_data = mem_resp_payload_mask_gp[mem_cmd_msg_type_i];
    assign cmd_is_amo    = (mem_cmd_msg_type_i == e_bedrock_mem_amo);
    assign cmd_beats     = bp_me_stream_beats(mem_cmd_size_i, data_width_p);
    assign hdr_idx       = mem_cmd_addr_i[lg_beat_bytes_lp +: idx_width_lp];
    // AMOs are always a single beat even if the size field asks for more
    assign cmd_streams     = cmd_has_data  & ~cmd_is_amo & (cmd_beats > cw_lp'(1));
    assign resp_streams    = resp_has_data & ~cmd_is_amo & (cmd_beats > cw_lp'(1));
    assign hdr_single_beat = ~cmd_streams;

    // Beat counter / wrap index
    logic                    ctr_load, ctr_incr, ctr_final;
    logic [idx_width_lp-1:0] ctr_idx;

    assign ctr_load = (state_q == e_ready) & cmd_hs;
    assign ctr_incr = ((state_q == e_wr_stream) & cmd_hs)
                    | ((state_q == e_resp) & resp_hs & ~resp_last_q);

    bp_me_mem_beat_counter #(
        .idx_width_p (idx_width_lp)
    ) u_beat_counter (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .load_i      (ctr_load),
        .start_idx_i (hdr_idx),
        .beats_i     (cmd_beats),
        .incr_i      (ctr_incr),
        .idx_o       (ctr_idx),
        .final_o     (ctr_final)
    );

    // Sub-beat write alignment: place the low 2^size bytes at the address offset
    int                      sub_size_bytes, sub_off;
    logic [data_width_p-1:0] sub_wdata;
    logic [beat_bytes_lp-1:0] sub_wbe;

    always_comb begin
        sub_size_bytes = 1 << mem_cmd_size_i;
        sub_off        = int'(mem_cmd_addr_i[lg_beat_bytes_lp-1:0]);
        sub_wdata      = '0;
        sub_wbe        = '0;
        if (sub_size_bytes >= beat_bytes_lp) begin
            sub_wdata = mem_cmd_data_i;
            sub_wbe   = '1;
        end else begin
            for (int b = 0; b < beat_bytes_lp; b++) begin
                if ((b >= sub_off) && (b < sub_off + sub_size_bytes)) begin
                    sub_wbe[b]         = 1'b1;
                    sub_wdata[b*8 +: 8] = mem_cmd_data_i[(b - sub_off)*8 +: 8];
                end
            end
        end
    end

    // Memory write port select: header beat or a streamed write beat
    logic                     mem_we;
    logic [idx_width_lp-1:0]  mem_widx;
    logic [data_width_p-1:0]  mem_wdata;
    logic [beat_bytes_lp-1:0] mem_wbe;

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = hdr_idx;
        mem_wdata = sub_wdata;
        mem_wbe   = sub_wbe;
        if ((state_q == e_ready) && cmd_hs && cmd_has_data) begin
            mem_we = 1'b1;
        end else if ((state_q == e_wr_stream) && cmd_hs) begin
            mem_we    = 1'b1;
            mem_widx  = ctr_idx;
            mem_wdata = mem_cmd_data_i;
            mem_wbe   = '1;
        end
    end

    // Byte-enabled memory write
    always_ff @(posedge clk_i) begin
        // NOTE: the memory array has no reset; its contents are undefined until
        // written, and a reset must not disturb beats already stored.
        if (mem_we) begin
            for (int b = 0; b < beat_bytes_lp; b++) begin
                if (mem_wbe[b]) begin
                    mem_q[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Responder FSM with registered handshake and response outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q          <= e_ready;
            ready_q          <= 1'b0;
            resp_v_q         <= 1'b0;
            resp_last_q      <= 1'b0;
            resp_data_q      <= '0;
            resp_type_q      <= '0;
            resp_addr_q      <= '0;
            resp_size_q      <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            unique case (state_q)
                e_ready: begin
                    ready_q <= 1'b1;
                    if (cmd_hs) begin
                        resp_type_q <= mem_cmd_msg_type_i;
                        resp_addr_q <= mem_cmd_addr_i;
                        resp_size_q <= mem_cmd_size_i;
                        if (mem_cmd_last_i != hdr_single_beat) begin
                            protocol_error_q <= 1'b1;
                        end
                        if (cmd_streams) begin
                            state_q <= e_wr_stream;
                        end else begin
                            state_q     <= e_resp;
                            ready_q     <= 1'b0;
                            resp_v_q    <= 1'b1;
                            resp_last_q <= ~resp_streams;
                            resp_data_q <= resp_has_data ? mem_q[hdr_idx] : '0;
                        end
                    end
                end
                e_wr_stream: begin
                    if (cmd_hs) begin
                        if (mem_cmd_last_i != ctr_final) begin
                            protocol_error_q <= 1'b1;
                        end
                        if (ctr_final) begin
                            state_q     <= e_resp;
                            ready_q     <= 1'b0;
                            resp_v_q    <= 1'b1;
                            resp_last_q <= 1'b1;
                            resp_data_q <= '0;
                        end
                    end
                end
                e_resp: begin
                    if (resp_hs) begin
                        if (resp_last_q) begin
                            state_q     <= e_ready;
                            ready_q     <= 1'b1;
                            resp_v_q    <= 1'b0;
                            resp_last_q <= 1'b0;
                            resp_data_q <= '0;
                        end else begin
                            resp_data_q <= mem_q[ctr_idx];
                            resp_last_q <= ctr_final;
                        end
                    end
                end
                default: state_q <= e_ready;
            endcase
        end
    end

    assign mem_cmd_ready_and_o = ready_q;
    assign mem_resp_msg_type_o = resp_type_q;
    assign mem_resp_addr_o     = resp_addr_q;
    assign mem_resp_size_o     = resp_size_q;
    assign mem_resp_data_o     = resp_data_q;
    assign mem_resp_v_o        = resp_v_q;
    assign mem_resp_last_o     = resp_last_q;
    assign protocol_error_o    = protocol_error_q;

endmodule
